// File: rtl/nand_pkg.sv
// rtl/nand_pkg.sv - shared NAND controller opcodes, pin map and read-setup state type
package nand_pkg;

  localparam logic [7:0] CMD_READ1 = 8'h00;
  localparam logic [7:0] CMD_READ2 = 8'h30;

  localparam int CP_WE_N = 0;
  localparam int CP_CE_N = 1;
  localparam int CP_CLE  = 2;
  localparam int CP_ALE  = 3;
  localparam int CP_RE_N = 4;

  localparam logic [4:0] CPINS_IDLE = 5'b10011;

  typedef enum logic [2:0] {
    RS_IDLE,
    RS_XFER,
    RS_WAIT_WB,
    RS_WAIT_RB,
    RS_HANDOFF,
    RS_DONE
  } read_setup_state_t;

  typedef struct packed {
    logic       cle;
    logic       ale;
    logic [7:0] data;
  } bus_cycle_t;

  // RE# stays high for every state this block owns; the read sequencer drives it later.
  function automatic logic [4:0] cpins_word(input logic we_n, input logic ce_n,
                                            input logic cle, input logic ale);
    logic [4:0] w;
    w          = '0;
    w[CP_WE_N] = we_n;
    w[CP_CE_N] = ce_n;
    w[CP_CLE]  = cle;
    w[CP_ALE]  = ale;
    w[CP_RE_N] = 1'b1;
    return w;
  endfunction

  function automatic bus_cycle_t preamble_byte(input logic [2:0] idx,
                                               input logic [15:0] col,
                                               input logic [23:0] row);
    bus_cycle_t bc;
    bc = '{cle: 1'b0, ale: 1'b1, data: 8'h00};
    case (idx)
      3'd0:    bc = '{cle: 1'b1, ale: 1'b0, data: CMD_READ1};
      3'd1:    bc.data = col[7:0];
      3'd2:    bc.data = col[15:8];
      3'd3:    bc.data = row[7:0];
      3'd4:    bc.data = row[15:8];
      3'd5:    bc.data = row[23:16];
      3'd6:    bc = '{cle: 1'b1, ale: 1'b0, data: CMD_READ2};
      default: bc = '{cle: 1'b0, ale: 1'b0, data: 8'h00};
    endcase
    return bc;
  endfunction

endpackage

// File: rtl/nand_read_setup_if.sv
// rtl/nand_read_setup_if.sv - host handshake and flash pin bundle for the page-read setup block
interface nand_read_setup_if;

  logic        start;
  logic [15:0] column_addr;
  logic [23:0] row_addr;
  logic        rb_n;
  logic        read_complete;
  logic [4:0]  CPINS;
  logic [7:0]  io_out;
  logic        io_oe;
  logic        read_start;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    output start, column_addr, row_addr, rb_n, read_complete,
    input  CPINS, io_out, io_oe, read_start, busy, done, error
  );

  modport slave (
    input  start, column_addr, row_addr, rb_n, read_complete,
    output CPINS, io_out, io_oe, read_start, busy, done, error
  );

endinterface

// File: rtl/nand_rb_monitor.sv
// rtl/nand_rb_monitor.sv - R/B# two-flop synchronizer with busy-wait timeout counter
module nand_rb_monitor #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  input  logic rb_n,
  output logic ready,
  output logic timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic          rb_meta;
  logic          rb_sync;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;

  // cnt holds completed wait cycles, so cnt_inc counts the current one as well.
  assign cnt_inc = cnt + 1'b1;
  assign ready   = enable && rb_sync;
  assign timeout = enable && (cnt_inc == LIMIT);

  // Clearing forces the synchronizer to "busy" so a stale ready never short-cuts the wait.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rb_meta <= 1'b1;
      rb_sync <= 1'b1;
      cnt     <= '0;
    end else if (clear) begin
      rb_meta <= 1'b0;
      rb_sync <= 1'b0;
      cnt     <= '0;
    end else begin
      rb_meta <= rb_n;
      rb_sync <= rb_meta;
      if (enable && !timeout)
        cnt <= cnt_inc;
    end
  end

endmodule

// File: rtl/nand_read_setup.sv
// rtl/nand_read_setup.sv - ONFI page-read preamble issuer handing the bus to the read sequencer
module nand_read_setup
  import nand_pkg::*;
#(
  parameter int TWB_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic              clk,
  input logic              rst,
  nand_read_setup_if.slave bus
);

  localparam int WBW = $clog2(TWB_CYCLES + 1);
  localparam logic [WBW-1:0] WB_LAST = WBW'(TWB_CYCLES - 1);

  read_setup_state_t state;
  logic [2:0]        byte_idx;
  logic [1:0]        phase;
  logic [WBW-1:0]    wb_cnt;
  logic [15:0]       col_q;
  logic [23:0]       row_q;
  logic [4:0]        cpins;
  logic [7:0]        io_out;
  logic              io_oe;
  logic              read_start;
  logic              busy;
  logic              done;
  logic              error;
  logic              rb_en;
  logic              rb_clr;
  logic              rb_ready;
  logic              rb_timeout;
  bus_cycle_t        next_bc;

  assign rb_en   = (state == RS_WAIT_RB);
  assign rb_clr  = (state == RS_WAIT_WB);
  assign next_bc = preamble_byte(byte_idx + 3'd1, col_q, row_q);

  nand_rb_monitor #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rb_monitor (
    .clk     (clk),
    .rst     (rst),
    .enable  (rb_en),
    .clear   (rb_clr),
    .rb_n    (bus.rb_n),
    .ready   (rb_ready),
    .timeout (rb_timeout)
  );

  // Pin outputs are loaded together with the state they belong to, so they change only on clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RS_IDLE;
      byte_idx   <= '0;
      phase      <= '0;
      wb_cnt     <= '0;
      col_q      <= '0;
      row_q      <= '0;
      cpins      <= CPINS_IDLE;
      io_out     <= '0;
      io_oe      <= 1'b0;
      read_start <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        RS_IDLE: begin
          if (bus.start) begin
            state    <= RS_XFER;
            col_q    <= bus.column_addr;
            row_q    <= bus.row_addr;
            error    <= 1'b0;
            busy     <= 1'b1;
            byte_idx <= '0;
            phase    <= '0;
            cpins    <= cpins_word(1'b1, 1'b0, 1'b1, 1'b0);
            io_out   <= CMD_READ1;
            io_oe    <= 1'b1;
          end
        end
        RS_XFER: begin
          if (phase != 2'd3) begin
            phase          <= phase + 2'd1;
            // WE# low for phases 1 and 2, back high for phase 3
            cpins[CP_WE_N] <= (phase == 2'd2);
          end else if (byte_idx != 3'd6) begin
            byte_idx <= byte_idx + 3'd1;
            phase    <= '0;
            cpins    <= cpins_word(1'b1, 1'b0, next_bc.cle, next_bc.ale);
            io_out   <= next_bc.data;
          end else begin
            state  <= RS_WAIT_WB;
            wb_cnt <= '0;
            cpins  <= cpins_word(1'b1, 1'b0, 1'b0, 1'b0);
            io_out <= '0;
            io_oe  <= 1'b0;
          end
        end
        RS_WAIT_WB: begin
          if (wb_cnt == WB_LAST)
            state <= RS_WAIT_RB;
          else
            wb_cnt <= wb_cnt + 1'b1;
        end
        RS_WAIT_RB: begin
          if (rb_ready) begin
            state      <= RS_HANDOFF;
            read_start <= 1'b1;
          end else if (rb_timeout) begin
            state <= RS_IDLE;
            error <= 1'b1;
            busy  <= 1'b0;
            cpins <= CPINS_IDLE;
          end
        end
        RS_HANDOFF: begin
          if (bus.read_complete) begin
            state      <= RS_DONE;
            read_start <= 1'b0;
            done       <= 1'b1;
            cpins      <= CPINS_IDLE;
          end
        end
        RS_DONE: begin
          state <= RS_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= RS_IDLE;
          busy  <= 1'b0;
          cpins <= CPINS_IDLE;
          io_oe <= 1'b0;
        end
      endcase
    end
  end

  assign bus.CPINS      = cpins;
  assign bus.io_out     = io_out;
  assign bus.io_oe      = io_oe;
  assign bus.read_start = read_start;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.error      = error;

endmodule

// File: tb/tb_nand_read_setup.sv
// tb/tb_nand_read_setup.sv - directed bench for the NAND page-read setup block
module tb_nand_read_setup;

  localparam int TWB = 4;
  localparam int TMO = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;

  nand_read_setup_if bus();

  nand_read_setup #(
    .TWB_CYCLES    (TWB),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.done === 1'b1) done_cnt++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  // Start is sampled at edge 0; on return the bench sits in cycle 1.
  task automatic start_read(input logic [15:0] col, input logic [23:0] row);
    bus.column_addr = col;
    bus.row_addr    = row;
    bus.start       = 1'b1;
    cyc             = 0;
    tick();
    bus.start       = 1'b0;
  endtask

  task automatic check_preamble(input logic [55:0] bytes, input string tag);
    int   k;
    int   p;
    logic cle;
    logic ale;
    logic we_n;
    for (int c = 1; c <= 28; c++) begin
      k    = (c - 1) / 4;
      p    = (c - 1) % 4;
      cle  = (k == 0) || (k == 6);
      ale  = (k >= 1) && (k <= 5);
      we_n = !((p == 1) || (p == 2));
      chk($sformatf("%s cyc%0d CPINS", tag, c), 32'(bus.CPINS), 32'({1'b1, ale, cle, 1'b0, we_n}));
      chk($sformatf("%s cyc%0d io_out", tag, c), 32'(bus.io_out), 32'(bytes[8*k +: 8]));
      chk($sformatf("%s cyc%0d io_oe", tag, c), 32'(bus.io_oe), 32'h1);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start         = 1'b0;
    bus.column_addr   = '0;
    bus.row_addr      = '0;
    bus.rb_n          = 1'b1;
    bus.read_complete = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset CPINS", 32'(bus.CPINS), 32'h13);
    chk("reset io_out", 32'(bus.io_out), 32'h0);
    chk("reset io_oe", 32'(bus.io_oe), 32'h0);
    chk("reset read_start", 32'(bus.read_start), 32'h0);
    chk("reset busy", 32'(bus.busy), 32'h0);
    chk("reset done", 32'(bus.done), 32'h0);
    chk("reset error", 32'(bus.error), 32'h0);
    rst = 1'b0;
    tick();

    // Page read, R/B# rising 50 cycles after the 30h cycle
    bus.rb_n = 1'b0;
    start_read(16'h0123, 24'h045678);
    chk("A busy", 32'(bus.busy), 32'h1);
    check_preamble(56'h30_04_56_78_01_23_00, "A");
    chk("A wb CPINS", 32'(bus.CPINS), 32'h11);
    chk("A wb io_oe", 32'(bus.io_oe), 32'h0);
    run_to(78);
    bus.rb_n = 1'b1;
    tick();
    chk("A rs+1", 32'(bus.read_start), 32'h0);
    tick();
    chk("A rs+2", 32'(bus.read_start), 32'h0);
    tick();
    chk("A rs+3", 32'(bus.read_start), 32'h1);
    chk("A handoff CPINS", 32'(bus.CPINS), 32'h11);
    chk("A handoff io_oe", 32'(bus.io_oe), 32'h0);
    run_to(85);
    done_cnt = 0;
    bus.read_complete = 1'b1;
    tick();
    chk("A done", 32'(bus.done), 32'h1);
    chk("A done read_start", 32'(bus.read_start), 32'h0);
    chk("A done CPINS", 32'(bus.CPINS), 32'h13);
    bus.read_complete = 1'b0;
    tick();
    chk("A done pulse end", 32'(bus.done), 32'h0);
    chk("A idle busy", 32'(bus.busy), 32'h0);
    chk("A done count", 32'(done_cnt), 32'h1);

    // R/B# high throughout and read_complete already high: minimum latency path
    bus.rb_n = 1'b1;
    bus.read_complete = 1'b1;
    done_cnt = 0;
    start_read(16'hA5C3, 24'h0F1E2D);
    run_to(29);
    for (int c = 29; c <= 35; c++) begin
      chk($sformatf("B cyc%0d read_start", c), 32'(bus.read_start), 32'h0);
      chk($sformatf("B cyc%0d done", c), 32'(bus.done), 32'h0);
      tick();
    end
    chk("B read_start", 32'(bus.read_start), 32'h1);
    tick();
    chk("B done", 32'(bus.done), 32'h1);
    tick();
    chk("B done pulse end", 32'(bus.done), 32'h0);
    chk("B idle busy", 32'(bus.busy), 32'h0);
    chk("B done count", 32'(done_cnt), 32'h1);
    bus.read_complete = 1'b0;

    // R/B# stuck low: timeout at the 100th WAIT_RB cycle (cycles 33..132)
    bus.rb_n = 1'b0;
    done_cnt = 0;
    start_read(16'h1357, 24'h2468AC);
    run_to(132);
    chk("C pre error", 32'(bus.error), 32'h0);
    chk("C pre CPINS", 32'(bus.CPINS), 32'h11);
    chk("C pre busy", 32'(bus.busy), 32'h1);
    tick();
    chk("C error", 32'(bus.error), 32'h1);
    chk("C CPINS", 32'(bus.CPINS), 32'h13);
    chk("C busy", 32'(bus.busy), 32'h0);
    chk("C done", 32'(bus.done), 32'h0);
    repeat (5) tick();
    chk("C error sticky", 32'(bus.error), 32'h1);
    chk("C no done", 32'(done_cnt), 32'h0);

    // Next start clears error; start pulses during XFER and HANDOFF are ignored
    bus.rb_n = 1'b1;
    done_cnt = 0;
    start_read(16'hBEEF, 24'hCAFE12);
    chk("D error cleared", 32'(bus.error), 32'h0);
    run_to(10);
    bus.column_addr = 16'h1111;
    bus.row_addr    = 24'h222222;
    bus.start       = 1'b1;
    tick();
    bus.start = 1'b0;
    run_to(12);
    chk("D col hi", 32'(bus.io_out), 32'hBE);
    run_to(15);
    chk("D row lo", 32'(bus.io_out), 32'h12);
    run_to(19);
    chk("D row mid", 32'(bus.io_out), 32'hFE);
    run_to(23);
    chk("D row hi", 32'(bus.io_out), 32'hCA);
    run_to(27);
    chk("D cmd2", 32'(bus.io_out), 32'h30);
    run_to(36);
    chk("D read_start", 32'(bus.read_start), 32'h1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("D handoff hold", 32'(bus.read_start), 32'h1);
    chk("D handoff busy", 32'(bus.busy), 32'h1);
    chk("D handoff CPINS", 32'(bus.CPINS), 32'h11);
    run_to(40);
    bus.read_complete = 1'b1;
    tick();
    chk("D done", 32'(bus.done), 32'h1);
    bus.read_complete = 1'b0;
    repeat (4) tick();
    chk("D done count", 32'(done_cnt), 32'h1);
    chk("D idle busy", 32'(bus.busy), 32'h0);

    // Reset at byte 3 phase 1, then a full replay
    start_read(16'h0123, 24'h045678);
    run_to(14);
    chk("E pre CPINS", 32'(bus.CPINS), 32'h18);
    chk("E pre io_oe", 32'(bus.io_oe), 32'h1);
    chk("E pre io_out", 32'(bus.io_out), 32'h78);
    rst = 1'b1;
    #1;
    chk("E rst CPINS", 32'(bus.CPINS), 32'h13);
    chk("E rst io_oe", 32'(bus.io_oe), 32'h0);
    chk("E rst busy", 32'(bus.busy), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    start_read(16'h0123, 24'h045678);
    check_preamble(56'h30_04_56_78_01_23_00, "E");
    bus.read_complete = 1'b1;
    done_cnt = 0;
    run_to(40);
    chk("E done count", 32'(done_cnt), 32'h1);
    chk("E idle busy", 32'(bus.busy), 32'h0);
    bus.read_complete = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nand_read_setup.md
# nand_read_setup

Page-read command/address issuer for the NAND flash controller, directly upstream of the byte-read sequencer. Drives the ONFI page-read preamble on the shared control pins: command 00h, five address cycles, command 30h. Then waits out tWB and the array busy period on R/B#. It then hands the bus to the read sequencer by asserting `read_start` and holds CE low until the sequencer reports completion.

## Interface
Parameters:
- `TWB_CYCLES`, 4, clocks after the 30h WE# rising edge during which R/B# is ignored (≥1)
- `TIMEOUT_CYCLES`, 65535, max clocks waiting for R/B# high before error (≥1)

Ports:
- `clk`  in  1  system clock, all logic on posedge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  request page read; sampled only in IDLE
- `column_addr`  in  16  column address, latched on accepted start
- `row_addr`  in  24  row (page/block/LUN) address, latched on accepted start
- `rb_n`  in  1  flash ready/busy#, asynchronous, 1 = ready
- `read_complete`  in  1  completion level from the downstream read sequencer
- `CPINS`  out  5  [0]=WE#, [1]=CE#, [2]=CLE, [3]=ALE, [4]=RE#
- `io_out`  out  8  byte driven on flash IO
- `io_oe`  out  1  IO output enable
- `read_start`  out  1  level; tells the read sequencer to begin
- `busy`  out  1  high in any state except IDLE
- `done`  out  1  one-cycle pulse on successful completion
- `error`  out  1  R/B# timeout flag, sticky until the next accepted start

## Operation
- States: IDLE, XFER (7 bus writes), WAIT_WB, WAIT_RB, HANDOFF, DONE.
- IDLE: `start`=1 latches both addresses, clears `error`, enters XFER with byte index 0, phase 0. `start` in any other state is ignored.
- XFER byte sequence, index 0..6: 00h (CLE); col[7:0], col[15:8], row[7:0], row[15:8], row[23:16] (ALE); 30h (CLE).
- Each byte takes 4 phases:
  - p0: CLE/ALE per byte, `io_out` = byte, `io_oe`=1, WE#=1
  - p1, p2: WE#=0
  - p3: WE#=1, with CLE/ALE/io held
- After byte 6 p3, enter WAIT_WB with CLE=ALE=0 and `io_oe`=0.
- WAIT_WB: hold exactly `TWB_CYCLES` cycles, ignoring `rb_n`.
- WAIT_RB: watch `rb_n` through a 2-flop synchronizer.
  - Synchronized high moves the block to HANDOFF.
  - The counter reaching `TIMEOUT_CYCLES` sets `error`=1, drives CE#=1, and returns to IDLE with no `done`.
- HANDOFF: `read_start`=1, CE#=0, WE#=1, RE#=1 (the sequencer owns RE#), `io_oe`=0. When `read_complete`=1, clear `read_start` and go to DONE.
- DONE: CE#=1, `done`=1 for one cycle, then IDLE.
- CE# is 0 from XFER entry through HANDOFF. It is 1 in IDLE and DONE.
- `read_complete` outside HANDOFF is ignored.

## Timing
- Reset values (immediate, also mid-operation):
  - `CPINS`=5'b10011 (WE#=1, CE#=1, CLE=0, ALE=0, RE#=1)
  - `io_out`=0, `io_oe`=0, `read_start`=0, `busy`=0, `done`=0, `error`=0
  - state IDLE, counters 0, synchronizer flops 1
- Start accepted at edge 0. Byte k phase p is visible during cycle 1+4k+p, so the preamble spans cycles 1..28.
- WE# is low in cycles 2,3 (00h), 6,7, … 26,27 (30h).
- WAIT_WB occupies cycles 29 .. 28+`TWB_CYCLES`.
- `rb_n` rising is reflected at `read_start` 3 edges later: 2 sync + 1 state.
- A `rb_n` that is already high on WAIT_RB entry still costs the synchronizer latency only.
- Timeout counter width is $clog2(`TIMEOUT_CYCLES`+1). It clears on WAIT_RB entry and counts each WAIT_RB cycle. Error is declared on the cycle it equals `TIMEOUT_CYCLES`.
- `done` rises the cycle after `read_complete` is sampled high in HANDOFF.
- Minimum start-to-done: 28+`TWB_CYCLES`+4 cycles.

## Structure
- Shared package `nand_pkg`:
  - opcodes `CMD_READ1`=8'h00, `CMD_READ2`=8'h30
  - CPINS bit indices
  - CPINS idle constant 5'b10011
  - this block's state enum
- One sub-module: `nand_rb_monitor`, a 2-flop `rb_n` synchronizer plus timeout counter. It has enable and clear inputs and ready/timeout outputs, and is reusable by program/erase blocks.

## Test plan
- Read page: column 16'h0123, row 24'h04_5678, `rb_n` rises 50 cycles after 30h. Bench requires:
  - IO bytes 00,23,01,78,56,04,30, each latched on a WE# rise
  - CLE only on bytes 0 and 6; ALE only on bytes 1–5
  - `read_start`=1 three cycles after the `rb_n` rise
  - `done` pulse one cycle after `read_complete`, then CPINS=5'b10011
- `rb_n` held high throughout: no exit from WAIT_WB before `TWB_CYCLES` elapse, then `read_start` after synchronizer latency.
- `rb_n` stuck low with `TIMEOUT_CYCLES`=100: `error`=1 at the 100th WAIT_RB cycle, CE#=1, no `done`. The next start clears `error`.
- `start` pulsed during XFER and HANDOFF: ignored, addresses unchanged, exactly one `done`.
- `rst` asserted at byte 3 phase 1 (WE# low): CPINS=5'b10011 and `io_oe`=0 immediately. A subsequent start replays the full preamble from 00h.
- `read_complete` held high before HANDOFF: no early `done`. `done` only after HANDOFF is reached.
